// File: rtl/filter_load_sequencer.sv
// Loads DEPTH_F*WIDTH_F taps into filter SRAM, then emits one NoC packet per tap in row-major order.
// Latency: 3 cycles per packet (READ, WAIT, SEND) with pkt_ready high; first packet 3 edges after last write.
// Backpressure: tap_valid low stalls LOAD; pkt_ready low holds SEND with pkt stable and no SRAM access.
module filter_load_sequencer #(
    parameter int           WIDTH_DATA = 13,
    parameter int           DEPTH_F    = 5,
    parameter int           WIDTH_F    = 5,
    parameter int           ADDR_W     = 5,
    parameter logic [1:0]   DATA_TYPE  = 2'b00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  tap_valid,
    output logic                  tap_ready,
    input  logic [WIDTH_DATA-1:0] tap_data,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_waddr,
    output logic [WIDTH_DATA-1:0] mem_wdata,
    output logic                  mem_re,
    output logic [ADDR_W-1:0]     mem_raddr,
    input  logic [WIDTH_DATA-1:0] mem_rdata,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic [31:0]           pkt,
    output logic                  busy,
    output logic                  done
);

    localparam int N_TAPS = DEPTH_F * WIDTH_F;
    localparam logic [ADDR_W-1:0] LAST_WADDR = ADDR_W'(N_TAPS - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(WIDTH_F);
    localparam logic [7:0]        LAST_COL   = 8'(WIDTH_F - 1);
    localparam logic [7:0]        LAST_ROW   = 8'(DEPTH_F - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wcnt;
    logic [7:0]        row;
    logic [7:0]        col;
    logic              wr_fire;
    logic [ADDR_W-1:0] raddr_calc;
    logic [12:0]       rdata_field;

    assign wr_fire     = tap_valid && (state == S_LOAD);
    assign raddr_calc  = ADDR_W'(row) * ROW_STRIDE + ADDR_W'(col);
    assign rdata_field = 13'(mem_rdata);

    // Every output decodes the state register, so reset forces them all to zero at once.
    assign tap_ready = (state == S_LOAD);
    assign mem_we    = wr_fire;
    assign mem_waddr = wr_fire ? wcnt : '0;
    assign mem_wdata = wr_fire ? tap_data : '0;
    assign mem_re    = (state == S_READ);
    assign mem_raddr = (state == S_READ) ? raddr_calc : '0;
    assign pkt_valid = (state == S_SEND);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            wcnt  <= '0;
            row   <= '0;
            col   <= '0;
            pkt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (wr_fire) begin
                        if (wcnt == LAST_WADDR) begin
                            wcnt  <= '0;
                            state <= S_READ;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                S_READ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    pkt   <= {1'b0, DATA_TYPE, row, col, rdata_field};
                    state <= S_SEND;
                end
                S_SEND: begin
                    if (pkt_ready) begin
                        if (col == LAST_COL) begin
                            col <= '0;
                            row <= row + 8'd1;
                        end else begin
                            col <= col + 8'd1;
                        end
                        if ((row == LAST_ROW) && (col == LAST_COL)) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    row   <= '0;
                    col   <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_load_sequencer.sv
// Randomized bench for filter_load_sequencer with an SRAM model and a row-major packet reference model.
module tb_filter_load_sequencer;

    localparam int NT = 25;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        tap_valid;
    logic        tap_ready;
    logic [12:0] tap_data;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [12:0] mem_wdata;
    logic        mem_re;
    logic [4:0]  mem_raddr;
    logic [12:0] mem_rdata;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [31:0] pkt;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [12:0] exp_tap [NT];
    logic [12:0] sram    [32];
    int          wr_idx;
    int          pkt_idx;
    int          done_cnt;

    filter_load_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tap_valid (tap_valid),
        .tap_ready (tap_ready),
        .tap_data  (tap_data),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt       (pkt),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Filter SRAM: synchronous write, read data one cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) sram[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= sram[mem_raddr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Tap k sits at row k/WIDTH_F, col k%WIDTH_F.
    function automatic logic [31:0] exp_pkt(input int k);
        logic [7:0] r;
        logic [7:0] c;
        r = 8'(k / 5);
        c = 8'(k % 5);
        return {1'b0, 2'b00, r, c, exp_tap[k]};
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_tap_ready"}, 32'(tap_ready), 0);
        check({tag, "_mem_we"},    32'(mem_we),    0);
        check({tag, "_mem_waddr"}, 32'(mem_waddr), 0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_mem_re"},    32'(mem_re),    0);
        check({tag, "_mem_raddr"}, 32'(mem_raddr), 0);
        check({tag, "_pkt_valid"}, 32'(pkt_valid), 0);
        check({tag, "_pkt"},       pkt,            0);
        check({tag, "_busy"},      32'(busy),      0);
        check({tag, "_done"},      32'(done),      0);
    endtask

    // Write monitor: in-order writes of the expected taps, never on an idle stream cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!tap_valid) check("we_gap", 32'(mem_we), 0);
            if (mem_we) begin
                if (wr_idx < NT) begin
                    check("waddr", 32'(mem_waddr), 32'(wr_idx));
                    check("wdata", 32'(mem_wdata), 32'(exp_tap[wr_idx]));
                end else begin
                    check("extra_write", 32'(mem_we), 0);
                end
                wr_idx++;
            end
        end
    end

    // Packet monitor: every SEND cycle must show the next expected packet with no SRAM read.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_re) check("raddr", 32'(mem_raddr), 32'(pkt_idx));
            if (pkt_valid) begin
                check("re_in_send", 32'(mem_re), 0);
                if (pkt_idx < NT) begin
                    check(pkt_ready ? "pkt" : "pkt_stall", pkt, exp_pkt(pkt_idx));
                end else begin
                    check("extra_pkt", 32'(pkt_valid), 0);
                end
                if (pkt_ready) pkt_idx++;
            end
            if (done) begin
                done_cnt++;
                check("done_pos", 32'(pkt_idx), NT);
            end
        end
    end

    task automatic run_op(input int base, input int gap_pct, input int stall_idx,
                          input int n_stop, input bit spur);
        int i;
        int cyc;
        int stall_left;
        for (int k = 0; k < NT; k++) exp_tap[k] = 13'(base + k);
        wr_idx     = 0;
        pkt_idx    = 0;
        done_cnt   = 0;
        stall_left = 10;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        i   = 0;
        cyc = 0;
        while (i < NT && cyc < 1000) begin
            if (tap_ready && ($urandom_range(0, 99) >= gap_pct)) begin
                tap_valid = 1'b1;
                tap_data  = exp_tap[i];
                i++;
            end else begin
                tap_valid = 1'b0;
                tap_data  = 13'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        tap_valid = 1'b0;
        if (cyc >= 1000) check("load_timeout", 0, 1);
        cyc = 0;
        while (pkt_idx < n_stop && cyc < 2000) begin
            if (pkt_valid && pkt_idx == stall_idx && stall_left > 0) begin
                pkt_ready = 1'b0;
                stall_left--;
            end else begin
                pkt_ready = 1'b1;
            end
            if (spur && pkt_idx < 20) begin
                start     = 1'($urandom_range(0, 1));
                tap_valid = 1'($urandom_range(0, 1));
                tap_data  = 13'($urandom);
            end else begin
                start     = 1'b0;
                tap_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start     = 1'b0;
        tap_valid = 1'b0;
        if (cyc >= 2000) check("send_timeout", 0, 1);
        if (n_stop == NT) begin
            cyc = 0;
            while (done_cnt == 0 && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            repeat (3) @(posedge clk);
            #1;
            check("done_count", 32'(done_cnt), 1);
            check("pkt_count",  32'(pkt_idx),  NT);
            check("write_count", 32'(wr_idx),  NT);
            check("busy_after", 32'(busy),     0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        tap_valid = 1'b0;
        tap_data  = '0;
        pkt_ready = 1'b1;
        wr_idx    = 0;
        pkt_idx   = 0;
        done_cnt  = 0;
        #17;
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 0);
            check("idle_act",  32'({mem_we, mem_re, pkt_valid}), 0);
        end

        run_op(1, 0, -1, NT, 1'b0);
        run_op(1, 40, -1, NT, 1'b0);
        run_op(1, 0, 2, NT, 1'b0);

        run_op(1, 30, -1, 12, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(101, 0, -1, NT, 1'b0);

        run_op(int'($urandom_range(0, 8000)), 25, 7, NT, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
